// File: rtl/ps2_key_fifo_pkg.sv
// Shared definitions for the PS/2 key event queue.
//   - CPU window register offsets (read and write side)
//   - STATUS register bit positions
//   - queued key event layout, which matches ps2_key[9:0] bit for bit
package ps2_key_fifo_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CODE   = 2'd1;
  localparam logic [1:0] REG_FLAGS  = 2'd2;
  localparam logic [1:0] REG_FLUSH  = 2'd3;

  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_NE_BIT  = 6;

  localparam int KEY_EVT_W = 10;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with an asynchronous read of the head entry.
// Ports:
//   clk_sys, reset     clock, asynchronous active-high reset
//   push, push_data    enqueue request and its data
//   pop                dequeue request (ignored when empty)
//   flush              empties the queue; overrides push and pop
//   head_data          current head entry (asynchronous read)
//   full, empty        registered status flags
//   count              number of stored entries, 0..2**DEPTH_LOG2
//   push_drop          push refused because the queue was full
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  push_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  do_pop;
  logic                  do_push;

  // A pop in the same cycle frees a slot, so a push into a full queue
  // still succeeds when it coincides with a real pop.
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & ~flush & (~full | do_pop);
  assign push_drop = push & ~flush & full & ~do_pop;
  assign head_data = mem[head];

  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_d = count + 1'b1;
        2'b01:   count_d = count - 1'b1;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (flush) begin
        head <= tail;
      end else begin
        if (do_pop)  head <= head + 1'b1;
        if (do_push) tail <= tail + 1'b1;
      end
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == DEPTH_CNT);
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// Queues PS/2 key events from the HPS and exposes them to the CPU through
// a 4-byte window. Each flip of ps2_key[10] is one event.
// Ports:
//   clk_sys, reset   clock, asynchronous active-high reset
//   ps2_key[10:0]    [7:0] code, [8] extended, [9] pressed, [10] toggle
//   cs, addr         window select and register offset
//   rd_n, wr_n       active-low CPU strobes, held for several clocks
//   data_out         combinational read data
//   nonempty         high while at least one event is queued
// Read map: 0 STATUS {ovf, nonempty, 0, count[4:0]}, 1 CODE, 2 FLAGS
// {6'b0, pressed, extended} (pops), 3 reads 0. Any write to 3 flushes.
module ps2_key_fifo
  import ps2_key_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  data_out,
  output logic        nonempty
);

  logic       toggle_q;
  logic       primed;
  logic       rd_act, wr_act;
  logic       rd_act_q, wr_act_q;
  logic [1:0] rd_addr_q, wr_addr_q;
  logic       rd_fire, wr_fire;
  logic       push, pop, flush, ovf_clr;
  logic       overflow;

  logic [KEY_EVT_W-1:0] head_raw;
  key_evt_t             head_evt;
  logic                 fifo_full, fifo_empty, push_drop;
  logic [DEPTH_LOG2:0]  fifo_count;
  logic [4:0]           count5;

  assign rd_act = cs & ~rd_n;
  assign wr_act = cs & ~wr_n;

  // Side effects wait for the trailing edge so data_out stays put for the
  // whole read; the offset seen during the access is what gets acted on.
  assign rd_fire = rd_act_q & ~rd_act;
  assign wr_fire = wr_act_q & ~wr_act;

  assign push    = primed & (ps2_key[10] != toggle_q);
  assign pop     = rd_fire & (rd_addr_q == REG_FLAGS);
  assign ovf_clr = rd_fire & (rd_addr_q == REG_STATUS);
  assign flush   = wr_fire & (wr_addr_q == REG_FLUSH);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_q  <= 1'b0;
      primed    <= 1'b0;
      rd_act_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      overflow  <= 1'b0;
    end else begin
      // First cycle after reset only adopts the current toggle level.
      toggle_q <= ps2_key[10];
      primed   <= 1'b1;
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
      if (rd_act) rd_addr_q <= addr;
      if (wr_act) wr_addr_q <= addr;
      // A fresh drop outranks a coincident STATUS-read clear.
      if (flush)          overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH      (KEY_EVT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (ps2_key[9:0]),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .push_drop (push_drop)
  );

  assign head_evt = head_raw;
  assign nonempty = ~fifo_empty;
  assign count5   = 5'(fifo_count);

  always_comb begin
    data_out = 8'h00;
    unique case (addr)
      REG_STATUS: data_out = {overflow, nonempty, 1'b0, count5};
      REG_CODE:   data_out = fifo_empty ? 8'h00 : head_evt.code;
      REG_FLAGS:  data_out = fifo_empty ? 8'h00 :
                             {6'b0, head_evt.pressed, head_evt.extended};
      default:    data_out = 8'h00;
    endcase
  end

endmodule
